// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory and drives every datapath enable.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky HALT state with illegal_op=1.
module mc_control_fsm #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic [1:0]  ImmExt,
    output logic        MEM_WrEn,
    output logic        sb,
    output logic        lb,
`ifdef ILLEGAL_TRAP_EN
    output logic        illegal_op,
`endif
    output logic [3:0]  state_o
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IFETCH, S_DECODE, S_RTYPE_EX, S_IMM_EX, S_ALU_WB,
        S_BR_EX, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_HALT
    } state_e;

    typedef enum logic [2:0] {C_R, C_IMM, C_BR, C_LOAD, C_STORE, C_BAD} class_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    class_e     cls;
    logic [5:0] opcode;
    logic       cnt_done;
    logic       unused_instr_bits;

    assign opcode            = Instr[31:26];
    assign cnt_done          = (cnt_q == CNT_LAST);
    assign unused_instr_bits = ^Instr[25:4];
    assign state_o           = state_q;

    always_comb begin
        cls = C_BAD;
        case (opcode)
            OP_R:                                   cls = C_R;
            OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: cls = C_IMM;
            OP_BEQ, OP_BNE, OP_B:                    cls = C_BR;
            OP_LB, OP_LW:                            cls = C_LOAD;
            OP_SB, OP_SW:                            cls = C_STORE;
            default:                                 cls = C_BAD;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_INIT;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        ImmExt        = 2'b00;
        MEM_WrEn      = 1'b0;
        sb            = 1'b0;
        lb            = 1'b0;

        case (state_q)
            S_INIT: state_d = S_IFETCH;

            S_IFETCH: begin
                IR_LdEn = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                case (cls)
                    C_R:              state_d = S_RTYPE_EX;
                    C_IMM:            state_d = S_IMM_EX;
                    C_BR:             state_d = S_BR_EX;
                    C_LOAD, C_STORE:  state_d = S_MEM_ADDR;
`ifdef ILLEGAL_TRAP_EN
                    default:          state_d = S_HALT;
`else
                    default:          state_d = S_ALU_WB;
`endif
                endcase
            end

            S_RTYPE_EX: begin
                ALU_func = Instr[3:0];
                state_d  = S_ALU_WB;
            end

            S_IMM_EX: begin
                ALU_Bin_sel = 1'b1;
                case (opcode)
                    OP_LUI:  ImmExt = 2'b10;
                    OP_ANDI: begin ALU_func = ALU_AND; ImmExt = 2'b01; end
                    OP_ORI:  begin ALU_func = ALU_OR;  ImmExt = 2'b01; end
                    default: ImmExt = 2'b00;
                endcase
                state_d = S_ALU_WB;
            end

            // Unknown opcodes also land here and retire as a NOP with no write.
            S_ALU_WB: begin
                RF_WrEn = (cls == C_R) || (cls == C_IMM);
                PC_LdEn = 1'b1;
                state_d = S_IFETCH;
            end

            S_BR_EX: begin
                ALU_func = ALU_SUB;
                RF_B_sel = 1'b1;
                ImmExt   = 2'b11;
                PC_LdEn  = 1'b1;
                case (opcode)
                    OP_BEQ:  PC_sel = ALU_zero;
                    OP_BNE:  PC_sel = ~ALU_zero;
                    default: PC_sel = 1'b1;
                endcase
                state_d = S_IFETCH;
            end

            S_MEM_ADDR: begin
                ALU_Bin_sel = 1'b1;
                RF_B_sel    = 1'b1;
                cnt_d       = 4'd0;
                state_d     = (cls == C_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                lb = (opcode == OP_LB);
                if (cnt_done) begin
                    cnt_d   = 4'd0;
                    state_d = S_MEM_WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_MEM_WB: begin
                RF_WrEn       = 1'b1;
                RF_WrData_sel = 1'b1;
                lb            = (opcode == OP_LB);
                PC_LdEn       = 1'b1;
                state_d       = S_IFETCH;
            end

            // The PC advances together with the final write cycle.
            S_MEM_WR: begin
                MEM_WrEn = 1'b1;
                sb       = (opcode == OP_SB);
                RF_B_sel = 1'b1;
                if (cnt_done) begin
                    PC_LdEn = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_IFETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_INIT;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (MEM_LAT 1 and 3), table vectors, corner sequences, random stream.
module tb_mc_control_fsm;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_AND = 4'd2;
    localparam logic [3:0] F_OR  = 4'd3;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst_n_v [2];
    logic [31:0] instr_v [2];
    logic        zero_v  [2];
    logic [15:0] out_v   [2];
    logic [3:0]  st_v    [2];
`ifdef ILLEGAL_TRAP_EN
    logic        ill_v   [2];
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pc_ld, pc_sel, ir_ld, rf_wr, rf_sel, rf_b, bin_sel, mem_wr, sb_w, lb_w;
        logic [3:0] func;
        logic [1:0] imm;
        mc_control_fsm #(.MEM_LAT(g == 0 ? 1 : 3)) u_dut (
            .Clk           (Clk),
            .Reset_n       (rst_n_v[g]),
            .Instr         (instr_v[g]),
            .ALU_zero      (zero_v[g]),
            .PC_LdEn       (pc_ld),
            .PC_sel        (pc_sel),
            .IR_LdEn       (ir_ld),
            .RF_WrEn       (rf_wr),
            .RF_WrData_sel (rf_sel),
            .RF_B_sel      (rf_b),
            .ALU_Bin_sel   (bin_sel),
            .ALU_func      (func),
            .ImmExt        (imm),
            .MEM_WrEn      (mem_wr),
            .sb            (sb_w),
            .lb            (lb_w),
`ifdef ILLEGAL_TRAP_EN
            .illegal_op    (ill_v[g]),
`endif
            .state_o       (st_v[g])
        );
        assign out_v[g] = {pc_ld, pc_sel, ir_ld, rf_wr, rf_sel, rf_b, bin_sel, func, imm, mem_wr, sb_w, lb_w};
    end

    // Output vector layout: [15] PC_LdEn [14] PC_sel [13] IR_LdEn [12] RF_WrEn [11] RF_WrData_sel
    // [10] RF_B_sel [9] ALU_Bin_sel [8:5] ALU_func [4:3] ImmExt [2] MEM_WrEn [1] sb [0] lb
    function automatic logic [15:0] ov(input logic pcld, input logic pcsel, input logic irld,
                                       input logic rfwr, input logic rfsel, input logic rfb,
                                       input logic binsel, input logic [3:0] func, input logic [1:0] imm,
                                       input logic memwr, input logic sbb, input logic lbb);
        return {pcld, pcsel, irld, rfwr, rfsel, rfb, binsel, func, imm, memwr, sbb, lbb};
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs of one instruction, from the opcode rules and memory latency.
    task automatic model(input logic [31:0] instr, input logic zero, input int lat);
        logic [5:0]  op;
        logic [15:0] wb;
        logic        is_b;
        op = instr[31:26];
        wb = ov(1, 0, 0, 1, 0, 0, 0, F_ADD, 2'b00, 0, 0, 0);
        exp_q.push_back(ov(0, 0, 1, 0, 0, 0, 0, F_ADD, 2'b00, 0, 0, 0));
        exp_q.push_back(16'h0000);
        case (op)
            6'b100000: begin
                exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0, instr[3:0], 2'b00, 0, 0, 0));
                exp_q.push_back(wb);
            end
            6'b111000, 6'b110000: begin
                exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1, F_ADD, 2'b00, 0, 0, 0));
                exp_q.push_back(wb);
            end
            6'b111001: begin
                exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1, F_ADD, 2'b10, 0, 0, 0));
                exp_q.push_back(wb);
            end
            6'b110010: begin
                exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1, F_AND, 2'b01, 0, 0, 0));
                exp_q.push_back(wb);
            end
            6'b110011: begin
                exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1, F_OR, 2'b01, 0, 0, 0));
                exp_q.push_back(wb);
            end
            6'b000000, 6'b000001, 6'b111111: begin
                logic taken;
                taken = (op == 6'b000000) ? zero : (op == 6'b000001) ? !zero : 1'b1;
                exp_q.push_back(ov(1, taken, 0, 0, 0, 1, 0, F_SUB, 2'b11, 0, 0, 0));
            end
            6'b000011, 6'b001111: begin
                is_b = (op == 6'b000011);
                exp_q.push_back(ov(0, 0, 0, 0, 0, 1, 1, F_ADD, 2'b00, 0, 0, 0));
                for (int i = 0; i < lat; i++)
                    exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0, F_ADD, 2'b00, 0, 0, is_b));
                exp_q.push_back(ov(1, 0, 0, 1, 1, 0, 0, F_ADD, 2'b00, 0, 0, is_b));
            end
            6'b000111, 6'b011111: begin
                is_b = (op == 6'b000111);
                exp_q.push_back(ov(0, 0, 0, 0, 0, 1, 1, F_ADD, 2'b00, 0, 0, 0));
                for (int i = 0; i < lat; i++)
                    exp_q.push_back(ov(i == lat - 1, 0, 0, 0, 0, 1, 0, F_ADD, 2'b00, 1, is_b, 0));
            end
            default: exp_q.push_back(ov(1, 0, 0, 0, 0, 0, 0, F_ADD, 2'b00, 0, 0, 0));
        endcase
    endtask

    // Holds the idle instance in reset and brings instance g to the start of IFETCH.
    task automatic select_dut(input int g);
        logic [3:0] st_init;
        rst_n_v[0] = 1'b0;
        rst_n_v[1] = 1'b0;
        #1;
        check($sformatf("reset_outputs_d%0d", g), out_v[g], 0);
        @(posedge Clk); #1;
        rst_n_v[g] = 1'b1;
        @(negedge Clk);
        check($sformatf("init_outputs_d%0d", g), out_v[g], 0);
        st_init = st_v[g];
        @(posedge Clk); #1;
        checks++;
        if (st_v[g] == st_init) begin
            errors++;
            $display("FAIL state_advance_d%0d: got %0h, expected a change from %0h", g, st_v[g], st_init);
        end
    endtask

    task automatic run_model(input int g, input logic [31:0] instr, input logic zero);
        logic [15:0] e;
        int          cyc;
        instr_v[g] = instr;
        zero_v[g]  = zero;
        model(instr, zero, lat_of(g));
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge Clk);
            check($sformatf("model_d%0d_i%h_c%0d", g, instr, cyc), out_v[g], e);
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    typedef struct {
        int          d;
        logic [31:0] instr;
        logic        zero;
        int          cyc;
        logic        pcsel;
        int          rfwr;
        int          memwr;
        int          lbc;
        int          sbc;
    } vec_t;

    vec_t vt [$];

    task automatic add_vec(input int d, input logic [31:0] instr, input logic zero, input int cyc,
                           input logic pcsel, input int rfwr, input int memwr, input int lbc, input int sbc);
        vec_t v;
        v.d = d; v.instr = instr; v.zero = zero; v.cyc = cyc; v.pcsel = pcsel;
        v.rfwr = rfwr; v.memwr = memwr; v.lbc = lbc; v.sbc = sbc;
        vt.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc, rfwr, memwr, lbc, sbc;
        logic        pcsel, done;
        logic [15:0] o;
        instr_v[v.d] = v.instr;
        zero_v[v.d]  = v.zero;
        cyc = 0; rfwr = 0; memwr = 0; lbc = 0; sbc = 0; pcsel = 1'b0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge Clk);
            o = out_v[v.d];
            if (cyc == 0) check($sformatf("vec_ir_ld_i%h", v.instr), o[13], 1);
            rfwr  += o[12];
            memwr += o[2];
            sbc   += o[1];
            lbc   += o[0];
            if (o[15]) begin
                pcsel = o[14];
                done  = 1'b1;
            end
            cyc++;
            @(posedge Clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL vec_timeout_i%h: got no PC_LdEn in %0d cycles, expected one", v.instr, cyc);
        end
        check($sformatf("vec_cycles_d%0d_i%h", v.d, v.instr), cyc, v.cyc);
        check($sformatf("vec_pc_sel_i%h_z%0d", v.instr, v.zero), pcsel, v.pcsel);
        check($sformatf("vec_rf_wr_i%h", v.instr), rfwr, v.rfwr);
        check($sformatf("vec_mem_wr_d%0d_i%h", v.d, v.instr), memwr, v.memwr);
        check($sformatf("vec_lb_d%0d_i%h", v.d, v.instr), lbc, v.lbc);
        check($sformatf("vec_sb_d%0d_i%h", v.d, v.instr), sbc, v.sbc);
    endtask

    logic [5:0] legal_ops [13];

    function automatic logic is_legal(input logic [5:0] op);
        for (int i = 0; i < 13; i++)
            if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int          cur;
        logic [31:0] r;
        logic [5:0]  op;

        rst_n_v[0] = 1'b0; rst_n_v[1] = 1'b0;
        instr_v[0] = '0;   instr_v[1] = '0;
        zero_v[0]  = 1'b0; zero_v[1]  = 1'b0;

        legal_ops[0] = 6'b100000; legal_ops[1]  = 6'b111000; legal_ops[2]  = 6'b111001;
        legal_ops[3] = 6'b110000; legal_ops[4]  = 6'b110010; legal_ops[5]  = 6'b110011;
        legal_ops[6] = 6'b000000; legal_ops[7]  = 6'b000001; legal_ops[8]  = 6'b111111;
        legal_ops[9] = 6'b000011; legal_ops[10] = 6'b001111; legal_ops[11] = 6'b000111;
        legal_ops[12] = 6'b011111;

        //      d  instr         z  cyc pcsel rf mem lb sb
        add_vec(1, 32'h80231030, 0, 4, 0, 1, 0, 0, 0);
        add_vec(1, 32'hC0000005, 0, 4, 0, 1, 0, 0, 0);
        add_vec(1, 32'hE0000010, 1, 4, 0, 1, 0, 0, 0);
        add_vec(1, 32'hE4001234, 0, 4, 0, 1, 0, 0, 0);
        add_vec(1, 32'hC80000FF, 0, 4, 0, 1, 0, 0, 0);
        add_vec(1, 32'hCC0000F0, 0, 4, 0, 1, 0, 0, 0);
        add_vec(1, 32'h0022000A, 1, 3, 1, 0, 0, 0, 0);
        add_vec(1, 32'h0022000A, 0, 3, 0, 0, 0, 0, 0);
        add_vec(1, 32'h04220003, 1, 3, 0, 0, 0, 0, 0);
        add_vec(1, 32'h04220003, 0, 3, 1, 0, 0, 0, 0);
        add_vec(1, 32'hFC000004, 0, 3, 1, 0, 0, 0, 0);
        add_vec(1, 32'h3C220008, 0, 7, 0, 1, 0, 0, 0);
        add_vec(1, 32'h0C220008, 0, 7, 0, 1, 0, 4, 0);
        add_vec(1, 32'h7C220008, 0, 6, 0, 0, 3, 0, 0);
        add_vec(1, 32'h1C220008, 0, 6, 0, 0, 3, 0, 3);
`ifndef ILLEGAL_TRAP_EN
        add_vec(1, 32'hA8000000, 0, 3, 0, 0, 0, 0, 0);
`endif
        add_vec(0, 32'h1C220008, 0, 4, 0, 0, 1, 0, 1);
        add_vec(0, 32'h0C220008, 0, 5, 0, 1, 0, 2, 0);
        add_vec(0, 32'h7C220008, 0, 4, 0, 0, 1, 0, 0);
        add_vec(0, 32'h80231030, 0, 4, 0, 1, 0, 0, 0);

        cur = 1;
        select_dut(1);
        foreach (vt[i]) begin
            if (vt[i].d != cur) begin
                cur = vt[i].d;
                select_dut(cur);
            end
            run_vec(vt[i]);
        end

        // Exact per-cycle sequences for the spec corner cases.
        select_dut(1);
        run_model(1, 32'h80231030, 0);
        run_model(1, 32'h0022000A, 1);
        run_model(1, 32'h0022000A, 0);
        run_model(1, 32'h0C220008, 0);
        select_dut(0);
        run_model(0, 32'h1C220008, 0);

        // Reset asserted during the first MEM_WR cycle of a store with MEM_LAT=3.
        select_dut(1);
        instr_v[1] = 32'h7C220008;
        zero_v[1]  = 1'b0;
        repeat (3) begin @(posedge Clk); #1; end
        @(negedge Clk);
        check("midwr_mem_wr_before_reset", out_v[1][2], 1);
        #1;
        rst_n_v[1] = 1'b0;
        #1;
        check("midwr_mem_wr_drops", out_v[1][2], 0);
        check("midwr_outputs_zero", out_v[1], 0);
        @(posedge Clk); #1;
        rst_n_v[1] = 1'b1;
        @(negedge Clk);
        check("midwr_init_zero", out_v[1], 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("midwr_then_ifetch", out_v[1], ov(0, 0, 1, 0, 0, 0, 0, F_ADD, 2'b00, 0, 0, 0));

`ifdef ILLEGAL_TRAP_EN
        select_dut(1);
        instr_v[1] = 32'hA8000000;
        repeat (2) begin @(posedge Clk); #1; end
        repeat (5) begin
            @(negedge Clk);
            check("halt_outputs_zero", out_v[1], 0);
            check("halt_illegal_op", ill_v[1], 1);
        end
        select_dut(1);
        check("halt_cleared_by_reset", ill_v[1], 0);
`endif

        for (int g = 1; g >= 0; g--) begin
            select_dut(g);
            for (int n = 0; n < 60; n++) begin
                r  = $urandom();
                op = legal_ops[$urandom_range(0, 12)];
`ifndef ILLEGAL_TRAP_EN
                if ($urandom_range(0, 7) == 0) begin
                    op = r[31:26];
                    while (is_legal(op)) op = op + 6'd5;
                end
`endif
                run_model(g, {op, r[25:0]}, 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
